// File: rtl/alu_writeback_pkg.sv
// Shared constants for the ALU writeback stage: flag bit positions, default widths and
// FSM state encoding. Build option: WB_FAULT_HALT_EN (see alu_writeback.sv).
package alu_writeback_pkg;

    localparam int unsigned DATA_W_DEF     = 16;
    localparam int unsigned FLAG_W_DEF     = 6;
    localparam int unsigned REG_ADDR_W_DEF = 4;

    localparam int unsigned ZERO_FLAG       = 0;
    localparam int unsigned CARRY_FLAG      = 1;
    localparam int unsigned NEGATIVE_FLAG   = 2;
    localparam int unsigned OVERFLOW_FLAG   = 3;
    localparam int unsigned PARITY_FLAG     = 4;
    localparam int unsigned INVALID_OP_FLAG = 5;

    typedef enum logic [0:0] {
        WB_RUN  = 1'b0,
        WB_HALT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/alu_writeback_fifo.sv
// Writeback FIFO: DEPTH entries of registered storage; head holds the last popped entry
// while empty so the register-file address/data lines stay stable.
module alu_writeback_fifo #(
    parameter int unsigned WIDTH = 21,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                last_q   <= mem[rd_ptr_q];
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: it is only observed through the count-qualified head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_comb begin
        empty = (count_q == '0);
        count = count_q;
        head  = empty ? last_q : mem[rd_ptr_q];
    end

endmodule

// File: rtl/alu_writeback.sv
// Execute-to-writeback stage: PSR/fault tracking and a FIFO draining into the register
// file. Define WB_FAULT_HALT_EN to stall intake after an invalid-op result until cleared.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FLAG_W     = FLAG_W_DEF,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [DATA_W-1:0]     C,
    input  logic [FLAG_W-1:0]     Flags,
    input  logic [REG_ADDR_W-1:0] In_Dest,
    input  logic                  In_WrEn,
    input  logic                  In_FlagUpd,
    output logic                  RF_WrEn,
    output logic [REG_ADDR_W-1:0] RF_WrAddr,
    output logic [DATA_W-1:0]     RF_WrData,
    input  logic                  RF_Ready,
    output logic [FLAG_W-1:0]     PSR,
    output logic                  CarryIn,
    output logic                  Fault,
    input  logic                  FaultClear
);

    localparam int unsigned ENTRY_W = 1 + REG_ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    wb_state_e         state_q, state_d;
    logic [FLAG_W-1:0] psr_q, psr_d;
    logic              fault_q, fault_d;

    logic               accept, invalid, full, empty, pop, head_we;
    logic [ENTRY_W-1:0] entry, head;
    logic [CNT_W-1:0]   count;

    assign invalid = Flags[INVALID_OP_FLAG];
    assign accept  = In_Valid & In_Ready;
    assign entry   = {In_WrEn & ~invalid, In_Dest, C};
    assign full    = (count == CNT_W'(DEPTH));
    // Entries that do not write are retired without waiting for the register file.
    assign pop     = ~empty & (RF_Ready | ~head_we);

    alu_writeback_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (accept),
        .pop   (pop),
        .wdata (entry),
        .head  (head),
        .empty (empty),
        .count (count)
    );

    assign {head_we, RF_WrAddr, RF_WrData} = head;
    assign RF_WrEn = ~empty & head_we;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= WB_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef WB_FAULT_HALT_EN
        unique case (state_q)
            WB_RUN:  if (accept && invalid) state_d = WB_HALT;
            WB_HALT: if (FaultClear) state_d = WB_RUN;
            default: state_d = WB_RUN;
        endcase
`else
        state_d = WB_RUN;
`endif
    end

    always_comb begin
        In_Ready = ~full & (state_q == WB_RUN);
    end

    // Order matters: an invalid-op set must win over a same-cycle clear.
    always_comb begin
        psr_d   = psr_q;
        fault_d = fault_q;
        if (accept && In_FlagUpd && !invalid) begin
            psr_d = Flags;
        end
        if (FaultClear) begin
            fault_d                = 1'b0;
            psr_d[INVALID_OP_FLAG] = 1'b0;
        end
        if (accept && invalid) begin
            fault_d                = 1'b1;
            psr_d[INVALID_OP_FLAG] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            psr_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            psr_q   <= psr_d;
            fault_q <= fault_d;
        end
    end

    assign PSR     = psr_q;
    assign CarryIn = psr_q[CARRY_FLAG];
    assign Fault   = fault_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Randomised bench for alu_writeback: a queue-based reference model predicts status and
// head state each cycle; a monitor checks every register-file write against a scoreboard.
module tb_alu_writeback;
    import alu_writeback_pkg::*;

    localparam int DEPTH = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        In_Valid, In_Ready, In_WrEn, In_FlagUpd;
    logic [15:0] C;
    logic [5:0]  Flags;
    logic [3:0]  In_Dest;
    logic        RF_WrEn, RF_Ready;
    logic [3:0]  RF_WrAddr;
    logic [15:0] RF_WrData;
    logic [5:0]  PSR;
    logic        CarryIn, Fault, FaultClear;

    alu_writeback #(
        .DATA_W     (16),
        .FLAG_W     (6),
        .REG_ADDR_W (4),
        .DEPTH      (DEPTH)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .C          (C),
        .Flags      (Flags),
        .In_Dest    (In_Dest),
        .In_WrEn    (In_WrEn),
        .In_FlagUpd (In_FlagUpd),
        .RF_WrEn    (RF_WrEn),
        .RF_WrAddr  (RF_WrAddr),
        .RF_WrData  (RF_WrData),
        .RF_Ready   (RF_Ready),
        .PSR        (PSR),
        .CarryIn    (CarryIn),
        .Fault      (Fault),
        .FaultClear (FaultClear)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit        we;
        bit [3:0]  addr;
        bit [15:0] data;
    } ent_t;

    ent_t      mq[$];
    ent_t      sb[$];
    ent_t      m_last;
    bit [5:0]  m_psr;
    bit        m_fault, m_halt;
    int        checks = 0;
    int        errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_last  = '{we: 1'b0, addr: 4'h0, data: 16'h0};
        m_psr   = '0;
        m_fault = 1'b0;
        m_halt  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model over the coming edge, then check.
    task automatic drive(input bit v, input bit [15:0] c, input bit [5:0] f, input bit [3:0] d,
                         input bit we, input bit fu, input bit rdy, input bit fc);
        bit   acc, inv, pop_now;
        ent_t e;
        In_Valid = v; C = c; Flags = f; In_Dest = d; In_WrEn = we; In_FlagUpd = fu;
        RF_Ready = rdy; FaultClear = fc;
        inv     = f[INVALID_OP_FLAG];
        acc     = v && (mq.size() < DEPTH) && !m_halt;
        pop_now = (mq.size() > 0) && (rdy || !mq[0].we);
        if (pop_now) m_last = mq.pop_front();
        if (acc) begin
            e = '{we: we && !inv, addr: d, data: c};
            mq.push_back(e);
            if (e.we) sb.push_back(e);
        end
        if (acc && fu && !inv) m_psr = f;
        if (fc) begin
            m_psr[INVALID_OP_FLAG] = 1'b0;
            m_fault = 1'b0;
        end
        if (acc && inv) begin
            m_psr[INVALID_OP_FLAG] = 1'b1;
            m_fault = 1'b1;
        end
`ifdef WB_FAULT_HALT_EN
        if (m_halt && fc) m_halt = 1'b0;
        else if (acc && inv) m_halt = 1'b1;
`endif
        @(posedge CLK);
        #1;
        chk("psr", int'(PSR), int'(m_psr));
        chk("fault", int'(Fault), int'(m_fault));
        chk("carry_in", int'(CarryIn), int'(m_psr[CARRY_FLAG]));
        chk("in_ready", int'(In_Ready), int'((mq.size() < DEPTH) && !m_halt));
        if (mq.size() > 0) begin
            chk("rf_wren", int'(RF_WrEn), int'(mq[0].we));
            chk("head_addr", int'(RF_WrAddr), int'(mq[0].addr));
            chk("head_data", int'(RF_WrData), int'(mq[0].data));
        end else begin
            chk("rf_wren_empty", int'(RF_WrEn), 0);
            chk("hold_addr", int'(RF_WrAddr), int'(m_last.addr));
            chk("hold_data", int'(RF_WrData), int'(m_last.data));
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 6'h0, 4'h0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    // Scoreboard monitor: every handshaken register-file write must match the next expected.
    always @(negedge CLK) begin
        ent_t e;
        if (RESET && RF_WrEn && RF_Ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write",
                         RF_WrAddr, RF_WrData);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", int'(RF_WrAddr), int'(e.addr));
                chk("wr_data", int'(RF_WrData), int'(e.data));
            end
        end
    end

    initial begin
        bit [5:0] f;
        RESET = 1'b0;
        In_Valid = 0; C = 0; Flags = 0; In_Dest = 0; In_WrEn = 0; In_FlagUpd = 0;
        RF_Ready = 0; FaultClear = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_in_ready", int'(In_Ready), 1);
        chk("rst_rf_wren", int'(RF_WrEn), 0);
        chk("rst_psr", int'(PSR), 0);
        chk("rst_addr", int'(RF_WrAddr), 0);
        chk("rst_data", int'(RF_WrData), 0);
        RESET = 1'b1;

        // Single write appears the cycle after accept.
        drive(1'b1, 16'h0008, 6'h0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Back-pressure: third entry waits for the first pop.
        drive(1'b1, 16'h1111, 6'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h2222, 6'h0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h3333, 6'h0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h3333, 6'h0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 16'h3333, 6'h0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Carry feedback: set by a flag update, kept by a non-updating op.
        drive(1'b1, 16'h00aa, 6'(1 << CARRY_FLAG), 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 16'h00bb, 6'h0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Invalid op: fault, no write; then clear.
        drive(1'b1, 16'hdead, 6'(1 << INVALID_OP_FLAG), 4'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 16'h0123, 6'h0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        drive(1'b0, 16'h0, 6'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Clear coinciding with a new invalid op: the set wins.
        drive(1'b1, 16'hbeef, 6'(1 << INVALID_OP_FLAG), 4'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1);
        drive(1'b0, 16'h0, 6'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);

        for (int i = 0; i < 600; i++) begin
            f = 6'($urandom);
            if ($urandom_range(0, 9) != 0) f[INVALID_OP_FLAG] = 1'b0;
            drive($urandom_range(0, 9) < 7, 16'($urandom), f, 4'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0);
        end
        drive(1'b0, 16'h0, 6'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Reset while two entries are queued discards them immediately.
        drive(1'b1, 16'h4444, 6'(1 << CARRY_FLAG), 4'd10, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 16'h5555, 6'h0, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        In_Valid = 1'b0;
        #2;
        RESET = 1'b0;
        #1;
        chk("mid_rst_in_ready", int'(In_Ready), 1);
        chk("mid_rst_rf_wren", int'(RF_WrEn), 0);
        chk("mid_rst_psr", int'(PSR), 0);
        chk("mid_rst_fault", int'(Fault), 0);
        model_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        drive(1'b1, 16'h6666, 6'h0, 4'd12, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
